// File: rtl/bwn_fc_score.sv
// Binary-weight fully-connected scoring layer: accumulates one saturating
// score per class over a frame of FEAT_NUM features, then emits packed scores.
module bwn_fc_score #(
  parameter int CLASS_NUM = 3,
  parameter int D_WL      = 16,
  parameter int IN_WL     = 8,
  parameter int FEAT_NUM  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [IN_WL-1:0]          feat,
  input  logic [CLASS_NUM-1:0]      weight,
  output logic                      in_ready,
  output logic [CLASS_NUM*D_WL-1:0] data,
  output logic                      o_valid,
  output logic                      sat
);

  localparam int CNT_W = $clog2(FEAT_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FEAT_NUM - 1);
  localparam logic [D_WL-1:0]  SAT_MAX  = {1'b0, {(D_WL-1){1'b1}}};
  localparam logic [D_WL-1:0]  SAT_MIN  = {1'b1, {(D_WL-1){1'b0}}};

  typedef enum logic {ACC, DONE} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [CLASS_NUM-1:0][D_WL-1:0]  acc;
  logic [CLASS_NUM-1:0][D_WL-1:0]  acc_nxt;
  logic [CLASS_NUM-1:0]            clamp;
  logic                            sat_f;
  logic [D_WL:0]                   feat_pos;
  logic [D_WL:0]                   feat_neg;
  logic [D_WL:0]                   addend;
  logic [D_WL:0]                   sum;

  always_comb begin
    in_ready = (state == ACC);
  end

  // One extra bit keeps -(-2^(IN_WL-1)) and acc+addend exact; overflow of the
  // D_WL-bit score shows up as the top two bits of the sum disagreeing.
  always_comb begin
    feat_pos = {{(D_WL+1-IN_WL){feat[IN_WL-1]}}, feat};
    feat_neg = -feat_pos;
    acc_nxt  = '0;
    clamp    = '0;
    addend   = '0;
    sum      = '0;
    for (int unsigned k = 0; k < CLASS_NUM; k++) begin
      addend = weight[k] ? feat_pos : feat_neg;
      sum    = {acc[k][D_WL-1], acc[k]} + addend;
      if (sum[D_WL] != sum[D_WL-1]) begin
        clamp[k]   = 1'b1;
        acc_nxt[k] = sum[D_WL] ? SAT_MIN : SAT_MAX;
      end else begin
        acc_nxt[k] = sum[D_WL-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      cnt     <= '0;
      acc     <= '0;
      sat_f   <= 1'b0;
      data    <= '0;
      o_valid <= 1'b0;
      sat     <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          o_valid <= 1'b0;
          if (in_valid) begin
            acc <= acc_nxt;
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              data    <= acc_nxt;
              sat     <= sat_f | (|clamp);
              o_valid <= 1'b1;
              state   <= DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              sat_f <= sat_f | (|clamp);
            end
          end
        end
        DONE: begin
          // Frame state is cleared here; data/sat keep the emitted result.
          o_valid <= 1'b0;
          acc     <= '0;
          sat_f   <= 1'b0;
          state   <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_bwn_fc_score.sv
// Scoreboard bench for bwn_fc_score: default instance plus a D_WL=10 instance
// to exercise saturation.
module tb_bwn_fc_score;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  feat;
  logic [2:0]  weight;
  logic        in_ready;
  logic [47:0] data;
  logic        o_valid;
  logic        sat;

  logic        v10;
  logic [7:0]  feat10;
  logic [2:0]  w10;
  logic        rdy10;
  logic [29:0] data10;
  logic        ov10;
  logic        sat10;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned sent  = 0;
  int unsigned acc_seen = 0;
  logic [48:0] q[$];
  logic [30:0] q10[$];
  logic [47:0] last_data;
  logic [7:0]  rf[16];
  logic [2:0]  rw[16];

  always #5 clk = ~clk;

  bwn_fc_score #(.CLASS_NUM(3), .D_WL(16), .IN_WL(8), .FEAT_NUM(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .feat(feat), .weight(weight),
    .in_ready(in_ready), .data(data), .o_valid(o_valid), .sat(sat)
  );

  bwn_fc_score #(.CLASS_NUM(3), .D_WL(10), .IN_WL(8), .FEAT_NUM(16)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(v10), .feat(feat10), .weight(w10),
    .in_ready(rdy10), .data(data10), .o_valid(ov10), .sat(sat10)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int argmax3(input logic [47:0] d);
    int best = 0;
    for (int k = 1; k < 3; k++)
      if ($signed(d[k*16 +: 16]) > $signed(d[best*16 +: 16])) best = k;
    return best;
  endfunction

  // Reference scores computed with plain integers and explicit clamping.
  function automatic logic [48:0] model16();
    logic [47:0] d = '0;
    logic        s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int a = 0;
      for (int i = 0; i < 16; i++) begin
        int f = int'($signed(rf[i]));
        a = rw[i][k] ? a + f : a - f;
        if (a > 32767) begin a = 32767; s = 1'b1; end
        if (a < -32768) begin a = -32768; s = 1'b1; end
      end
      d[k*16 +: 16] = 16'(a);
    end
    return {s, d};
  endfunction

  task automatic send(input logic [7:0] f, input logic [2:0] w);
    bit ok = 0;
    in_valid = 1'b1;
    feat     = f;
    weight   = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) sent++;
    else chk("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send10(input logic [7:0] f, input logic [2:0] w);
    bit ok = 0;
    v10    = 1'b1;
    feat10 = f;
    w10    = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = rdy10;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send10_timeout", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      feat   = 8'($urandom);
      weight = 3'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (q.size() != 0 || q10.size() != 0); n++) @(posedge clk);
    #1;
    chk("q_drain", 64'(q.size()), 64'd0);
    chk("q10_drain", 64'(q10.size()), 64'd0);
  endtask

  // Output monitor for the default instance: scoreboard, pulse width, latency.
  initial begin
    logic prev_ov  = 1'b0;
    logic prev_acc = 1'b0;
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (o_valid) begin
        chk("ov_pulse", 64'(prev_ov), 64'd0);
        chk("rdy_in_done", 64'(in_ready), 64'd0);
        chk("latency", 64'(prev_acc), 64'd1);
        last_data = data;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("data", 64'(data), 64'(e[47:0]));
          chk("sat", 64'(sat), 64'(e[48]));
        end else begin
          chk("unexpected_ov", 64'(o_valid), 64'd0);
        end
      end
      prev_acc = in_valid && in_ready && rst_n;
      if (prev_acc) acc_seen++;
      prev_ov = o_valid;
    end
  end

  initial begin
    logic [30:0] e;
    forever begin
      @(negedge clk);
      if (ov10) begin
        if (q10.size() > 0) begin
          e = q10.pop_front();
          chk("data10", 64'(data10), 64'(e[29:0]));
          chk("sat10", 64'(sat10), 64'(e[30]));
        end else begin
          chk("unexpected_ov10", 64'(ov10), 64'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; feat = '0; weight = '0;
    v10 = 1'b0; feat10 = '0; w10 = '0;
    #22 rst_n = 1'b1;
    #1;
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_ov", 64'(o_valid), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // constant features, mixed weights
    q.push_back({1'b0, 48'h0010_FFF0_0010});
    for (int i = 0; i < 16; i++) send(8'd1, 3'b101);
    idle(3);

    // ramp features with alternating weights
    q.push_back({1'b0, 48'hFF78_FFF8_0008});
    for (int i = 1; i <= 16; i++) send(8'(i), (i % 2 == 1) ? 3'b010 : 3'b001);
    idle(2);

    // class 2 should win the downstream argmax
    q.push_back({1'b0, 48'h0050_FFB0_FFB0});
    for (int i = 0; i < 16; i++) send(8'd5, 3'b100);
    idle(2);
    drain();
    chk("judge_class", 64'(argmax3(last_data)), 64'd2);

    // random frames with random gaps, including back-to-back frame starts
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] = 8'($urandom);
        rw[i] = 3'($urandom);
      end
      rf[3] = 8'h80;
      rw[3] = 3'b000;
      q.push_back(model16());
      for (int i = 0; i < 16; i++) begin
        send(rf[i], rw[i]);
        if ($urandom_range(0, 1) == 1 && i != 15) idle($urandom_range(1, 3));
      end
    end
    idle(2);
    drain();
    chk("accept_count", 64'(acc_seen), 64'(sent));

    // saturation on the narrow instance, both directions of weight
    q10.push_back({1'b1, {3{10'h1FF}}});
    for (int i = 0; i < 16; i++) send10(8'd127, 3'b111);
    q10.push_back({1'b1, {3{10'h1FF}}});
    for (int i = 0; i < 16; i++) send10(8'h80, 3'b000);
    v10 = 1'b0;
    drain();

    // async reset mid-frame: outputs clear without a clock edge
    for (int i = 0; i < 7; i++) send(8'd1, 3'b111);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 64'(data), 64'd0);
    chk("arst_ov", 64'(o_valid), 64'd0);
    chk("arst_sat", 64'(sat), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back({1'b0, 48'h0010_0010_0010});
    for (int i = 0; i < 16; i++) send(8'd1, 3'b111);
    idle(3);
    drain();
    chk("accept_count_final", 64'(acc_seen), 64'(sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
